// File: rtl/ft_replay_sequencer.sv
// ft_replay_sequencer
// Replays the shadow GPR file (x1..x(NUM_REG-1)) and then the shadow PC into
// a halted core through its debug register-write port, then pulses done_o.
//
// Optional feature macro: FT_REPLAY_VERIFY_EN
//   defined   -> each GPR write is read back and compared; a difference sets
//                the sticky mismatch_o flag.
//   undefined -> write-only replay; mismatch_o is tied to 0.
//
// Ports
//   clk_i, rst_ni                  clock, async active-low reset
//   start_i, abort_i               sequence control (abort has priority)
//   sgpr_raddr_o / sgpr_rdata_i    shadow register file read port
//   spc_i                          shadow PC
//   dbg_req_o/we_o/pc_o/addr_o/wdata_o, dbg_gnt_i, dbg_rdata_i
//                                  core debug access port (req/gnt)
//   busy_o, done_o, aborted_o, mismatch_o   status
module ft_replay_sequencer #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic                  abort_i,
  output logic [ADDR_WIDTH-1:0] sgpr_raddr_o,
  input  logic [DATA_WIDTH-1:0] sgpr_rdata_i,
  input  logic [DATA_WIDTH-1:0] spc_i,
  output logic                  dbg_req_o,
  output logic                  dbg_we_o,
  output logic                  dbg_pc_o,
  output logic [ADDR_WIDTH-1:0] dbg_addr_o,
  output logic [DATA_WIDTH-1:0] dbg_wdata_o,
  input  logic                  dbg_gnt_i,
  input  logic [DATA_WIDTH-1:0] dbg_rdata_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  aborted_o,
  output logic                  mismatch_o
);

  localparam int NUM_REG = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REG-1);

`ifdef FT_REPLAY_VERIFY_EN
  typedef enum logic [2:0] {IDLE, FETCH, WRITE, RD_REQ, CHECK, PC_WRITE, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, FETCH, WRITE, PC_WRITE, DONE} state_t;
`endif

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  aborted_q;

`ifdef FT_REPLAY_VERIFY_EN
  logic                  mis_set;
  logic                  mismatch_q;
`endif

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    sgpr_raddr_o = '0;
    dbg_req_o    = 1'b0;
    dbg_we_o     = 1'b0;
    dbg_pc_o     = 1'b0;
    dbg_addr_o   = '0;
    dbg_wdata_o  = '0;
    done_o       = 1'b0;
`ifdef FT_REPLAY_VERIFY_EN
    mis_set      = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        // x0 is hardwired zero in the core, so replay starts at x1
        if (start_i) begin
          state_d = FETCH;
          idx_d   = ADDR_WIDTH'(1);
        end
      end
      FETCH: begin
        sgpr_raddr_o = idx_q;
        state_d      = WRITE;
      end
      WRITE: begin
        dbg_req_o   = 1'b1;
        dbg_we_o    = 1'b1;
        dbg_addr_o  = idx_q;
        dbg_wdata_o = data_q;
        if (dbg_gnt_i) begin
`ifdef FT_REPLAY_VERIFY_EN
          state_d = RD_REQ;
`else
          // compare before incrementing so idx never wraps to x0
          if (idx_q == LAST_IDX) state_d = PC_WRITE;
          else begin
            idx_d   = idx_q + ADDR_WIDTH'(1);
            state_d = FETCH;
          end
`endif
        end
      end
`ifdef FT_REPLAY_VERIFY_EN
      RD_REQ: begin
        dbg_req_o  = 1'b1;
        dbg_addr_o = idx_q;
        if (dbg_gnt_i) state_d = CHECK;
      end
      CHECK: begin
        // read data arrives the cycle after the read grant, i.e. now
        mis_set = (dbg_rdata_i != data_q);
        if (idx_q == LAST_IDX) state_d = PC_WRITE;
        else begin
          idx_d   = idx_q + ADDR_WIDTH'(1);
          state_d = FETCH;
        end
      end
`endif
      PC_WRITE: begin
        dbg_req_o   = 1'b1;
        dbg_we_o    = 1'b1;
        dbg_pc_o    = 1'b1;
        dbg_wdata_o = spc_i;
        if (dbg_gnt_i) state_d = DONE;
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // abort wins over everything, including a grant in the same cycle
    if (abort_i && state_q != IDLE) begin
      state_d = IDLE;
      idx_d   = idx_q;
`ifdef FT_REPLAY_VERIFY_EN
      mis_set = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      data_q    <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      aborted_q <= abort_i && (state_q != IDLE);
      if (state_q == FETCH) data_q <= sgpr_rdata_i;
    end
  end

`ifdef FT_REPLAY_VERIFY_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                          mismatch_q <= 1'b0;
    else if (state_q == IDLE && start_i)  mismatch_q <= 1'b0;
    else if (mis_set)                     mismatch_q <= 1'b1;
  end
  assign mismatch_o = mismatch_q;
`else
  logic unused_rdata;
  assign unused_rdata = ^dbg_rdata_i;
  assign mismatch_o   = 1'b0;
`endif

  assign busy_o    = (state_q != IDLE);
  assign aborted_o = aborted_q;

endmodule

// File: tb/tb_ft_replay_sequencer.sv
// Bench for ft_replay_sequencer: transaction-level scoreboard of the expected
// debug-port accesses, a core register model fed by granted writes, and
// directed runs (full replay, grant stall, abort, mid-run reset, ignored
// start/abort, readback mismatch when FT_REPLAY_VERIFY_EN is defined).
module tb_ft_replay_sequencer;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 32;
`ifdef FT_REPLAY_VERIFY_EN
  localparam bit VER = 1'b1;
`else
  localparam bit VER = 1'b0;
`endif
  localparam int BASE_DONE = VER ? 126 : 64;

  logic          clk_i, rst_ni, start_i, abort_i;
  logic [AW-1:0] sgpr_raddr_o;
  logic [DW-1:0] sgpr_rdata_i, spc_i;
  logic          dbg_req_o, dbg_we_o, dbg_pc_o;
  logic [AW-1:0] dbg_addr_o;
  logic [DW-1:0] dbg_wdata_o;
  logic          dbg_gnt_i;
  logic [DW-1:0] dbg_rdata_i;
  logic          busy_o, done_o, aborted_o, mismatch_o;

  ft_replay_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i),
    .sgpr_raddr_o(sgpr_raddr_o), .sgpr_rdata_i(sgpr_rdata_i), .spc_i(spc_i),
    .dbg_req_o(dbg_req_o), .dbg_we_o(dbg_we_o), .dbg_pc_o(dbg_pc_o),
    .dbg_addr_o(dbg_addr_o), .dbg_wdata_o(dbg_wdata_o), .dbg_gnt_i(dbg_gnt_i),
    .dbg_rdata_i(dbg_rdata_i), .busy_o(busy_o), .done_o(done_o),
    .aborted_o(aborted_o), .mismatch_o(mismatch_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Shadow register file; it presents data for the address within the FETCH
  // cycle, so the end-of-FETCH capture sees the addressed entry.
  logic [DW-1:0] shadow [NR];
  assign sgpr_rdata_i = shadow[sgpr_raddr_o];

  // Core register model
  logic [DW-1:0] core [NR];
  logic [DW-1:0] rd_pending;
  logic          corrupt_x7;

  // Expected debug-port transactions in order
  typedef struct {
    bit            pc;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } txn_t;
  txn_t expq[$];

  task automatic build_expect();
    txn_t t;
    expq.delete();
    for (int i = 1; i < NR; i++) begin
      t.pc = 1'b0; t.we = 1'b1; t.addr = AW'(i); t.data = shadow[i];
      expq.push_back(t);
      if (VER) begin
        t.we = 1'b0; t.data = '0;
        expq.push_back(t);
      end
    end
    t.pc = 1'b1; t.we = 1'b1; t.addr = '0; t.data = spc_i;
    expq.push_back(t);
  endtask

  // Grant driver: grants every cycle except while stalling a chosen GPR write.
  int            stall_left = 0;
  logic [AW-1:0] stall_addr = '0;
  initial begin
    dbg_gnt_i   = 1'b1;
    dbg_rdata_i = '0;
    forever begin
      @(posedge clk_i); #1;
      dbg_rdata_i = rd_pending;
      if (stall_left > 0 && dbg_req_o && dbg_we_o && !dbg_pc_o && dbg_addr_o == stall_addr) begin
        dbg_gnt_i = 1'b0;
        stall_left--;
      end else dbg_gnt_i = 1'b1;
    end
  end

  // Compare process
  int            busy_cnt = 0;
  int            n_gpr_wr = 0;
  logic [DW-1:0] last_pc = '0;
  initial begin
    logic          p_req, p_gnt, p_we, p_pc;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_wdata;
    txn_t          e;
    p_req = 1'b0; p_gnt = 1'b0; p_we = 1'b0; p_pc = 1'b0; p_addr = '0; p_wdata = '0;
    rd_pending = '0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) p_req = 1'b0;
      else begin
        if (!busy_o)
          chk("idle_outputs", {dbg_req_o, dbg_we_o, dbg_pc_o, dbg_addr_o, dbg_wdata_o, sgpr_raddr_o}, '0);
        else busy_cnt++;
        if (p_req && !p_gnt && dbg_req_o)
          chk("stall_hold", {dbg_we_o, dbg_pc_o, dbg_addr_o, dbg_wdata_o}, {p_we, p_pc, p_addr, p_wdata});
        if (dbg_req_o && dbg_gnt_i && !abort_i) begin
          if (expq.size() == 0) chk("unexpected_txn", 1, 0);
          else begin
            e = expq.pop_front();
            chk("txn_kind", {dbg_pc_o, dbg_we_o}, {e.pc, e.we});
            chk("txn_addr", dbg_addr_o, e.addr);
            if (e.we) chk("txn_wdata", dbg_wdata_o, e.data);
          end
          if (dbg_we_o && !dbg_pc_o) begin
            core[dbg_addr_o] = dbg_wdata_o;
            n_gpr_wr++;
          end
          if (dbg_pc_o) last_pc = dbg_wdata_o;
          if (!dbg_we_o)
            rd_pending = (corrupt_x7 && dbg_addr_o == AW'(7)) ? 32'hDEADBEEF : core[dbg_addr_o];
        end
        p_req = dbg_req_o; p_gnt = dbg_gnt_i; p_we = dbg_we_o; p_pc = dbg_pc_o;
        p_addr = dbg_addr_o; p_wdata = dbg_wdata_o;
      end
    end
  end

  int c0 = 0;

  task automatic do_start();
    @(posedge clk_i); #2;
    build_expect();
    busy_cnt = 0;
    n_gpr_wr = 0;
    start_i  = 1'b1;
    c0       = cyc;
    @(posedge clk_i); #2;
    start_i  = 1'b0;
  endtask

  task automatic finish_run(input string nm, input int exp_cyc);
    int rel;
    rel = -1;
    for (int k = 0; k < 400; k++) begin
      if (done_o) begin
        rel = cyc - c0;
        break;
      end
      @(posedge clk_i); #2;
    end
    chk({nm, "_done_cycle"}, rel, exp_cyc);
    @(posedge clk_i); #2;
    chk({nm, "_done_pulse_busy"}, {done_o, busy_o}, 2'b00);
    chk({nm, "_queue_left"}, expq.size(), 0);
    chk({nm, "_gpr_writes"}, n_gpr_wr, 31);
    chk({nm, "_busy_cycles"}, busy_cnt, exp_cyc);
  endtask

  task automatic wait_for(input string nm, input int sel, input logic [AW-1:0] a);
    bit hit;
    hit = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk_i); #2;
      if (sel == 0 && dbg_req_o && dbg_we_o && !dbg_pc_o && dbg_addr_o == a) hit = 1'b1;
      if (sel == 1 && sgpr_raddr_o == a) hit = 1'b1;
      if (hit) break;
    end
    chk({nm, "_reached"}, hit, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b0; start_i = 1'b0; abort_i = 1'b0; spc_i = 32'h0000_0080;
    corrupt_x7 = 1'b0;
    for (int i = 0; i < NR; i++) begin
      shadow[i] = 32'hA5A5_0000 + i;
      core[i]   = '0;
    end
    repeat (2) @(posedge clk_i);
    #1;
    chk("reset_outputs", {busy_o, done_o, aborted_o, mismatch_o, dbg_req_o, dbg_we_o, dbg_pc_o,
                          dbg_addr_o, dbg_wdata_o, sgpr_raddr_o}, '0);
    @(posedge clk_i); #2;
    rst_ni = 1'b1;

    // Full replay, grant always high
    do_start();
    chk("run1_busy_at_c1", busy_o, 1'b1);
    finish_run("run1", BASE_DONE);
    chk("run1_x1", core[1], 32'hA5A5_0001);
    chk("run1_x31", core[31], 32'hA5A5_001F);
    chk("run1_pc", last_pc, 32'h0000_0080);
    chk("run1_mismatch", mismatch_o, 1'b0);

    // Grant withheld 3 cycles on x5's write
    stall_addr = AW'(5);
    stall_left = 3;
    do_start();
    finish_run("stall", BASE_DONE + 3);

    // Abort in WRITE of x10 with grant high
    do_start();
    wait_for("abort", 0, AW'(10));
    abort_i = 1'b1;
    @(posedge clk_i); #2;
    abort_i = 1'b0;
    chk("abort_pulse", {aborted_o, busy_o, done_o}, 3'b100);
    @(posedge clk_i); #2;
    chk("abort_pulse_end", {aborted_o, busy_o, done_o}, 3'b000);
    do_start();
    finish_run("after_abort", BASE_DONE);

    // Reset during FETCH of x20
    do_start();
    wait_for("rst", 1, AW'(20));
    rst_ni = 1'b0;
    #1;
    chk("midrun_reset_outputs", {busy_o, done_o, aborted_o, mismatch_o, dbg_req_o, dbg_we_o, dbg_pc_o,
                                 dbg_addr_o, dbg_wdata_o, sgpr_raddr_o}, '0);
    @(posedge clk_i); #2;
    rst_ni = 1'b1;
    @(posedge clk_i); #2;
    chk("post_reset_no_pulse", {done_o, aborted_o, busy_o}, 3'b000);
    do_start();
    finish_run("after_reset", BASE_DONE);

    // start while busy is ignored; abort while idle is ignored
    do_start();
    repeat (9) @(posedge clk_i);
    #2;
    start_i = 1'b1;
    @(posedge clk_i); #2;
    start_i = 1'b0;
    finish_run("busy_start", BASE_DONE);
    abort_i = 1'b1;
    @(posedge clk_i); #2;
    abort_i = 1'b0;
    chk("idle_abort", {aborted_o, busy_o}, 2'b00);
    @(posedge clk_i); #2;
    chk("idle_abort_next", {aborted_o, busy_o, done_o}, 3'b000);

`ifdef FT_REPLAY_VERIFY_EN
    // Readback of x7 corrupted by the core
    corrupt_x7 = 1'b1;
    do_start();
    finish_run("verify_bad", 126);
    chk("mismatch_set", mismatch_o, 1'b1);
    @(posedge clk_i); #2;
    chk("mismatch_sticky", mismatch_o, 1'b1);
    corrupt_x7 = 1'b0;
    do_start();
    chk("mismatch_cleared", mismatch_o, 1'b0);
    finish_run("verify_good", 126);
    chk("mismatch_clean_run", mismatch_o, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
